// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM state encoding,
// external command codes, grant codes, requester identity and default widths.
package reg_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    EXT_NOP     = 2'b00,
    EXT_WR_INC  = 2'b01,
    EXT_WR_HOLD = 2'b10,
    EXT_CLR     = 2'b11
  } ext_cmd_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_EXT  = 2'b01;
  localparam logic [1:0] GRANT_SPI  = 2'b10;

  typedef enum logic {
    SRC_EXT = 1'b0,
    SRC_SPI = 1'b1
  } src_t;

  // Only the two write commands touch the bank; NOP and CLR only affect ptr.
  function automatic logic ext_cmd_writes(input logic [1:0] cmd);
    return (cmd == EXT_WR_INC) || (cmd == EXT_WR_HOLD);
  endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Bundle of request inputs and bank/status outputs of the write arbiter.
//   ext_wr/ext_cmd/ext_data : manual requester (level WR, command, data)
//   spi_valid/spi_data/spi_ready : SPI word stream
//   rb_we/rb_addr/rb_wdata  : register-bank write port
//   ptr/grant/busy/ext_drop : status
// slave  = arbiter side, master = requester/bank side.
interface reg_wr_arbiter_if
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              ext_wr;
  logic [1:0]        ext_cmd;
  logic [DATA_W-1:0] ext_data;
  logic              spi_valid;
  logic [DATA_W-1:0] spi_data;
  logic              spi_ready;
  logic              rb_we;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_wdata;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        grant;
  logic              busy;
  logic              ext_drop;

  modport slave (
    input  ext_wr, ext_cmd, ext_data, spi_valid, spi_data,
    output spi_ready, rb_we, rb_addr, rb_wdata, ptr, grant, busy, ext_drop
  );

  modport master (
    output ext_wr, ext_cmd, ext_data, spi_valid, spi_data,
    input  spi_ready, rb_we, rb_addr, rb_wdata, ptr, grant, busy, ext_drop
  );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : level input
//   rise  : high in the cycle where d is 1 and was 0 at the previous edge
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/reg_wr_arbiter.sv
// Sole owner of the register-bank write port. Captures requests from the
// manual WR strobe and the SPI stream, arbitrates round-robin when both are
// pending, and sequences each write IDLE -> WRITE -> DONE against ptr.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset (0 = reset)
//   bus  : reg_wr_arbiter_if.slave (requests in, bank write + status out)
module reg_wr_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  reg_wr_arbiter_if.slave  bus
);

  logic              ext_rise;
  state_t            state;
  src_t              served;
  src_t              last;
  logic              ext_pend;
  logic              spi_pend;
  logic [1:0]        ext_cmd_q;
  logic [DATA_W-1:0] ext_data_q;
  logic [DATA_W-1:0] spi_data_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ext_drop_q;

  rise_detect u_ext_rise (
    .clk   (clk),
    .rst_n (rst),
    .d     (bus.ext_wr),
    .rise  (ext_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      served     <= SRC_EXT;
      last       <= SRC_EXT;
      ext_pend   <= 1'b0;
      spi_pend   <= 1'b0;
      ext_cmd_q  <= EXT_NOP;
      ext_data_q <= '0;
      spi_data_q <= '0;
      ptr_q      <= '0;
      ext_drop_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so capture and FSM both see pre-edge
      // pend values; the DONE-state clear below wins over nothing it races.
      // A new edge while the previous ext request is still pending (including
      // its DONE cycle) is lost and flagged; buffers stay untouched.
      if (ext_rise) begin
        if (ext_pend) begin
          ext_drop_q <= 1'b1;
        end else begin
          ext_pend   <= 1'b1;
          ext_cmd_q  <= bus.ext_cmd;
          ext_data_q <= bus.ext_data;
        end
      end

      if (bus.spi_valid && !spi_pend) begin
        spi_pend   <= 1'b1;
        spi_data_q <= bus.spi_data;
      end

      unique case (state)
        ST_IDLE: begin
          if (ext_pend || spi_pend) begin
            state <= ST_WRITE;
            if (ext_pend && spi_pend)
              served <= (last == SRC_EXT) ? SRC_SPI : SRC_EXT;
            else
              served <= spi_pend ? SRC_SPI : SRC_EXT;
          end
        end
        ST_WRITE: state <= ST_DONE;
        ST_DONE: begin
          state <= ST_IDLE;
          last  <= served;
          if (served == SRC_SPI) begin
            spi_pend <= 1'b0;
            ptr_q    <= ptr_q + ADDR_W'(1);
          end else begin
            ext_pend <= 1'b0;
            if (ext_cmd_q == EXT_WR_INC)   ptr_q <= ptr_q + ADDR_W'(1);
            else if (ext_cmd_q == EXT_CLR) ptr_q <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so reset drops rb_we at once and
  // no input reaches an output combinationally.
  logic in_write;
  assign in_write = (state == ST_WRITE);

  assign bus.spi_ready = ~spi_pend;
  assign bus.rb_we     = in_write && ((served == SRC_SPI) || ext_cmd_writes(ext_cmd_q));
  assign bus.rb_addr   = in_write ? ptr_q : '0;
  assign bus.rb_wdata  = !in_write ? '0 : (served == SRC_SPI) ? spi_data_q : ext_data_q;
  assign bus.ptr       = ptr_q;
  assign bus.grant     = (state == ST_IDLE)  ? GRANT_NONE :
                         (served == SRC_SPI) ? GRANT_SPI : GRANT_EXT;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.ext_drop  = ext_drop_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed latency/boundary steps
// followed by randomized transactions scored against a transaction-level model.
module tb_reg_wr_arbiter;
  import reg_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wr_arbiter_if bus ();

  reg_wr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t wr_q[$];
  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  m_ptr       = 0;
  bit  m_last_spi  = 1'b0;

  // Bank-write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && bus.rb_we) wr_q.push_back('{addr: bus.rb_addr, data: bus.rb_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one served request at a time, bank/pointer rules only.
  task automatic model_reset();
    m_ptr      = 0;
    m_last_spi = 1'b0;
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic model_ext(input logic [1:0] cmd, input logic [7:0] d);
    if (cmd == 2'b01 || cmd == 2'b10) exp_q.push_back('{addr: 4'(m_ptr), data: d});
    if (cmd == 2'b01)      m_ptr = (m_ptr + 1) % 16;
    else if (cmd == 2'b11) m_ptr = 0;
    m_last_spi = 1'b0;
  endtask

  task automatic model_spi(input logic [7:0] d);
    exp_q.push_back('{addr: 4'(m_ptr), data: d});
    m_ptr      = (m_ptr + 1) % 16;
    m_last_spi = 1'b1;
  endtask

  task automatic drain(input string tag);
    wr_t a, e;
    repeat (12) step();
    check({tag, " wr_count"}, wr_q.size(), exp_q.size());
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      a = wr_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " addr"}, a.addr, e.addr);
      check({tag, " data"}, a.data, e.data);
    end
    wr_q.delete();
    exp_q.delete();
    check({tag, " ptr"}, bus.ptr, m_ptr);
    check({tag, " busy"}, bus.busy, 1'b0);
  endtask

  task automatic ext_pulse(input logic [1:0] cmd, input logic [7:0] d);
    bus.ext_cmd  = cmd;
    bus.ext_data = d;
    bus.ext_wr   = 1'b1;
    step();
    bus.ext_wr   = 1'b0;
  endtask

  task automatic spi_send(input logic [7:0] d);
    logic acc;
    int   n;
    bus.spi_valid = 1'b1;
    bus.spi_data  = d;
    n = 0;
    do begin
      acc = bus.spi_ready;
      step();
      n++;
    end while (!acc && n < 40);
    check("spi accept", acc, 1'b1);
    check("spi_ready while pending", bus.spi_ready, 1'b0);
    bus.spi_valid = 1'b0;
  endtask

  logic [1:0] r_cmd;
  logic [7:0] r_de, r_ds;
  int         r_kind;

  initial begin
    rst = 1'b0;
    bus.ext_wr = 1'b0; bus.ext_cmd = 2'b00; bus.ext_data = '0;
    bus.spi_valid = 1'b0; bus.spi_data = '0;

    // 1: reset state, then mid-write reset abort
    step(); step();
    check("rst ptr", bus.ptr, 4'd0);
    check("rst rb_we", bus.rb_we, 1'b0);
    check("rst spi_ready", bus.spi_ready, 1'b1);
    check("rst busy", bus.busy, 1'b0);
    check("rst grant", bus.grant, 2'b00);
    check("rst ext_drop", bus.ext_drop, 1'b0);
    rst = 1'b1;
    step();
    bus.spi_valid = 1'b1; bus.spi_data = 8'hAA;
    step();
    bus.spi_valid = 1'b0;
    step();
    check("abort pre rb_we", bus.rb_we, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort rb_we", bus.rb_we, 1'b0);
    check("abort busy", bus.busy, 1'b0);
    check("abort spi_ready", bus.spi_ready, 1'b1);
    step();
    rst = 1'b1;
    model_reset();
    drain("abort");

    // 2: single ext write+inc with latency, then held WR gives one write
    ext_pulse(2'b01, 8'h01);
    step();
    check("ext write rb_we", bus.rb_we, 1'b1);
    check("ext write addr", bus.rb_addr, 4'd0);
    check("ext write data", bus.rb_wdata, 8'h01);
    check("ext write grant", bus.grant, 2'b01);
    step();
    check("ext done rb_we", bus.rb_we, 1'b0);
    check("ext done ptr", bus.ptr, 4'd0);
    step();
    check("ext after ptr", bus.ptr, 4'd1);
    model_ext(2'b01, 8'h01);
    bus.ext_cmd = 2'b01; bus.ext_data = 8'h02; bus.ext_wr = 1'b1;
    repeat (5) step();
    bus.ext_wr = 1'b0;
    model_ext(2'b01, 8'h02);
    drain("ext held");

    // 3: clear ptr, then four back-to-back SPI words
    ext_pulse(2'b11, 8'hFF);
    model_ext(2'b11, 8'hFF);
    drain("ext clr");
    spi_send(8'h05); spi_send(8'h03); spi_send(8'h08); spi_send(8'h0E);
    model_spi(8'h05); model_spi(8'h03); model_spi(8'h08); model_spi(8'h0E);
    drain("spi burst");

    // 4: simultaneous requests after reset (last=ext): SPI first
    rst = 1'b0; step(); rst = 1'b1; model_reset();
    bus.ext_cmd = 2'b01; bus.ext_data = 8'h44; bus.ext_wr = 1'b1;
    bus.spi_valid = 1'b1; bus.spi_data = 8'h55;
    step();
    bus.ext_wr = 1'b0; bus.spi_valid = 1'b0;
    step();
    check("rr first grant", bus.grant, 2'b10);
    check("rr first data", bus.rb_wdata, 8'h55);
    step(); step(); step();
    check("rr second grant", bus.grant, 2'b01);
    check("rr second data", bus.rb_wdata, 8'h44);
    check("rr second addr", bus.rb_addr, 4'd1);
    model_spi(8'h55); model_ext(2'b01, 8'h44);
    drain("rr");

    // 5: pointer wrap, clear, write-hold
    while (m_ptr != 15) begin
      r_ds = 8'($urandom);
      spi_send(r_ds);
      model_spi(r_ds);
      drain("fill");
    end
    spi_send(8'h09); model_spi(8'h09); drain("wrap");
    ext_pulse(2'b01, 8'h21); model_ext(2'b01, 8'h21); drain("pre clr");
    ext_pulse(2'b11, 8'h22); model_ext(2'b11, 8'h22); drain("clr");
    ext_pulse(2'b01, 8'h23); model_ext(2'b01, 8'h23); drain("pre hold");
    ext_pulse(2'b10, 8'h24); model_ext(2'b10, 8'h24); drain("hold");

    // 6: second edge while first ext request pending is dropped
    ext_pulse(2'b01, 8'h66);
    step();
    bus.ext_data = 8'h77; bus.ext_wr = 1'b1;
    step();
    bus.ext_wr = 1'b0;
    check("ext_drop set", bus.ext_drop, 1'b1);
    model_ext(2'b01, 8'h66);
    drain("drop");
    check("ext_drop sticky", bus.ext_drop, 1'b1);

    // Randomized transactions: ext only, spi only, or both in one cycle
    for (int i = 0; i < 40; i++) begin
      r_kind = int'($urandom_range(0, 2));
      r_cmd  = 2'($urandom_range(0, 3));
      r_de   = 8'($urandom);
      r_ds   = 8'($urandom);
      if (r_kind == 0) begin
        ext_pulse(r_cmd, r_de);
        model_ext(r_cmd, r_de);
      end else if (r_kind == 1) begin
        spi_send(r_ds);
        model_spi(r_ds);
      end else begin
        bus.ext_cmd = r_cmd; bus.ext_data = r_de; bus.ext_wr = 1'b1;
        bus.spi_valid = 1'b1; bus.spi_data = r_ds;
        step();
        bus.ext_wr = 1'b0; bus.spi_valid = 1'b0;
        if (m_last_spi) begin
          model_ext(r_cmd, r_de); model_spi(r_ds);
        end else begin
          model_spi(r_ds); model_ext(r_cmd, r_de);
        end
      end
      drain("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
